instruction_fetch: RTL
======================

# instruction_fetch

Program sequencer and fetch buffer that drives the instruction memory address and turns its registered one-cycle read data into a valid/ready instruction stream for the decode stage. On `start` it fetches sequentially from `start_pc` until the memory flags end of program (an all-zero NOP word returns `instr_valid` low) or the address space is exhausted. A credit-limited FIFO absorbs decode backpressure without dropping in-flight reads.

## Interface
- `INSTR_WIDTH`, 32, instruction word width
- `INSTR_MEM_ADDR_WIDTH`, 10, instruction memory address width (AW)
- `FIFO_DEPTH`, 4, output buffer entries; power of two, ≥ 2
- `clk` in 1: single clock; all state rises on posedge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle pulse; begins a program run from `start_pc`
- `start_pc` in AW: first fetch address, sampled with `start`
- `abort` in 1: synchronous; cancels the run and empties the buffer
- `mem_addr` out AW: instruction memory read address
- `mem_instr` in INSTR_WIDTH: memory read data, one cycle after `mem_addr`
- `mem_instr_valid` in 1: memory valid flag; low means end-of-program NOP
- `instr_data` out INSTR_WIDTH: head instruction word
- `instr_pc` out AW: address of the head instruction
- `instr_valid` out 1: head entry present
- `instr_ready` in 1: decode accepts the head this cycle
- `busy` out 1: run in progress (FETCH, LAST, DRAIN)
- `done` out 1: high in DONE until the next `start`

## Operation
- States: IDLE, FETCH, LAST, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE + `start`: pc ← `start_pc`, go to FETCH. `start` is ignored in FETCH, LAST and DRAIN.
- `mem_addr` is driven directly from pc.
- Issue in FETCH when fifo_count + req_q < FIFO_DEPTH. req_q is the one-cycle-delayed issue flag. Pops in the same cycle are not credited.
- On issue: req_q ← 1, pc ← pc+1. If the issued address is 2^AW−1, go to LAST. Issuing never wraps pc.
- Return handling: when req_q=1 and `mem_instr_valid`=1, push {`mem_instr`, pc_q} into the FIFO. pc_q is the issued address, delayed one cycle.
- When req_q=1 and `mem_instr_valid`=0: do not push; go to DRAIN. Any fetch issued in that same cycle returns next cycle and is discarded.
- LAST: no issue. Handle the final return as above, then go to DRAIN.
- DRAIN: no issue; returns are ignored. Go to DONE when the FIFO is empty and no pop is pending.
- Output: show-ahead FIFO. `instr_valid` = !empty. Pop when `instr_valid` && `instr_ready`.
- Simultaneous push and pop is allowed at any occupancy, including full.
- `abort` (any state): clear FIFO, clear req_q, go to IDLE. `abort` has priority over `start` in the same cycle.
- Reset values: `mem_addr` 0, `instr_data` 0, `instr_pc` 0, `instr_valid` 0, `busy` 0, `done` 0, req_q 0, FIFO empty.
- Asynchronous reset mid-run discards all in-flight state. The memory's own reset is synchronous, so a return that arrives in the first cycle after reset is ignored because req_q=0.

## Timing
- `start` is sampled at edge E0. `mem_addr`=`start_pc` after E0. The memory registers the word at E1; the FIFO pushes at E2. `instr_valid` rises after E2, so start-to-first-instruction latency is 2 cycles.
- Throughput with `instr_ready` held high: one instruction per cycle (occupancy 1 + req_q 1 < 4).
- Holding `instr_ready` low fills the FIFO to FIFO_DEPTH, then issue stops. The in-flight read is always covered by credit, so the FIFO never overflows.
- End of program: the NOP returns at cycle k. `done` rises one cycle after the last buffered entry is popped.

## Structure
- Package `tsp_fetch_pkg` contains:
  - `fetch_state_t` enum
  - `OPCODE_MSB`/`OPCODE_LSB` (31/24) and `OP_NOP` = 8'h00 constants, shared with decode
- Sub-module `fetch_fifo`: synchronous show-ahead FIFO with count output, parameterised by width and depth.
- Entries store {pc, instr}.

## Test plan
- Memory holds 0x01000000, 0x01000104, 0x03000800, 0x04000810, then NOP; `start_pc`=0; ready=1 → four outputs with pc 0..3 on consecutive cycles starting 2 cycles after `start`; `done` rises after the fourth pop; no output for address 4.
- Same program with `instr_ready` low for 6 cycles after the first output → FIFO holds 4 entries, `mem_addr` stops advancing, no entry is lost or duplicated, order is preserved.
- `start_pc`=1 → outputs pc 1..3 only; a `start` pulse during FETCH is ignored.
- Memory filled non-zero at 1020..1023; `start_pc`=1020 → 4 outputs, LAST entered after issuing 1023, `mem_addr` never wraps to 0, `done` asserts.
- `abort` asserted with 2 entries buffered and a read in flight → `instr_valid` 0 the next cycle, state IDLE, a late return is not pushed; a later `start` runs cleanly.
- `rst` asserted mid-run between clock edges → all outputs take reset values immediately; after release, `start` reproduces the first scenario exactly.

Source files
------------

// File: rtl/tsp_fetch_pkg.sv
// Shared types and constants for the fetch stage; the opcode field
// constants are also used by decode.
package tsp_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        DRAIN,
        DONE
    } fetch_state_t;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 24;
    localparam logic [7:0]  OP_NOP     = 8'h00;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. The head word is
// visible whenever the FIFO is non-empty; push and pop may coincide at any
// occupancy, including full.
module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked while empty so the output reads zero after reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by count,
    // so stale words are never observable and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program sequencer: issues sequential instruction-memory reads from a start
// address and buffers the registered returns for decode with credit control.
module instruction_fetch
    import tsp_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH          = 32,
    parameter int INSTR_MEM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_pc,
    input  logic                            abort,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [INSTR_WIDTH-1:0]          mem_instr,
    input  logic                            mem_instr_valid,
    output logic [INSTR_WIDTH-1:0]          instr_data,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_pc,
    output logic                            instr_valid,
    input  logic                            instr_ready,
    output logic                            busy,
    output logic                            done
);

    localparam int AW = INSTR_MEM_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = AW + INSTR_WIDTH;

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [AW-1:0]    pc;
    logic [AW-1:0]    pc_q;
    logic             req_q;
    logic             issue;
    logic             start_go;
    logic             pc_last;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;
    logic [EW-1:0]    head;

    assign pc_last  = (pc == '1);
    assign start_go = start && !abort && (state == IDLE || state == DONE);

    // Credit counts the read in flight; a pop this cycle is not credited.
    assign issue = (state == FETCH) && !abort
                && (int'(fifo_count) + int'(req_q) < FIFO_DEPTH);

    assign push = req_q && mem_instr_valid && !abort
               && (state == FETCH || state == LAST);
    assign pop  = instr_valid && instr_ready;

    // NOTE: state_n is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = FETCH;
            FETCH: begin
                if (req_q && !mem_instr_valid) state_n = DRAIN;
                else if (issue && pc_last)     state_n = LAST;
            end
            LAST:  state_n = DRAIN;
            DRAIN: if (fifo_empty) state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            pc_q  <= '0;
            req_q <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= issue;
            if (issue) pc_q <= pc;
            if (start_go)                pc <= start_pc;
            else if (issue && !pc_last)  pc <= pc + 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (push),
        .push_data ({pc_q, mem_instr}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign mem_addr    = pc;
    assign instr_valid = !fifo_empty;
    assign instr_data  = head[INSTR_WIDTH-1:0];
    assign instr_pc    = head[EW-1:INSTR_WIDTH];
    assign busy        = (state == FETCH) || (state == LAST) || (state == DRAIN);
    assign done        = (state == DONE);

endmodule
